// File: rtl/wfid_onehot_tracker.sv
// wfid_onehot_tracker: decodes wavefront IDs to one-hot and tracks a registered busy mask
// Ports: clk; rst (synchronous, active-low);
//   set_en/set_wfid allocate a slot, clr_en/clr_wfid release a slot;
//   decode_out/decode_valid: one-hot of the last accepted set, pulsed valid;
//   busy_mask/busy_count/all_busy: slot occupancy; range_err/proto_err: sticky errors.
// Optional: define WFID_TRACKER_FREE_ENCODE_EN to add free_wfid/free_valid,
//   the lowest free slot of the next busy mask.
module wfid_onehot_tracker #(
  parameter int NUM_SLOTS = 40,
  parameter int ID_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [ID_WIDTH-1:0]  set_wfid,
  input  logic                 clr_en,
  input  logic [ID_WIDTH-1:0]  clr_wfid,
  output logic [NUM_SLOTS-1:0] decode_out,
  output logic                 decode_valid,
  output logic [NUM_SLOTS-1:0] busy_mask,
  output logic [ID_WIDTH-1:0]  busy_count,
  output logic                 all_busy,
  output logic                 range_err,
`ifdef WFID_TRACKER_FREE_ENCODE_EN
  output logic [ID_WIDTH-1:0]  free_wfid,
  output logic                 free_valid,
`endif
  output logic                 proto_err
);
  // One extra bit so NUM_SLOTS == 2**ID_WIDTH still compares correctly
  localparam logic [ID_WIDTH:0] LIMIT = (ID_WIDTH+1)'(NUM_SLOTS);
  localparam logic [ID_WIDTH-1:0] FULL = ID_WIDTH'(NUM_SLOTS);
  logic set_ok, clr_ok, same_id, set_hit, clr_hit, inc, dec;
  logic [NUM_SLOTS-1:0] set_vec, clr_vec, busy_nxt;
  logic [ID_WIDTH-1:0] count_nxt;
  function automatic logic [NUM_SLOTS-1:0] onehot(input logic [ID_WIDTH-1:0] id);
    return {1'b0, id} < LIMIT ? NUM_SLOTS'(1) << id : '0;
  endfunction
  always_comb begin
    set_ok = set_en && {1'b0, set_wfid} < LIMIT;
    clr_ok = clr_en && {1'b0, clr_wfid} < LIMIT;
    set_vec = set_en ? onehot(set_wfid) : '0;
    clr_vec = clr_en ? onehot(clr_wfid) : '0;
    same_id = set_ok && clr_ok && set_wfid == clr_wfid;
    set_hit = |(busy_mask & set_vec);
    clr_hit = |(busy_mask & clr_vec);
    busy_nxt = (busy_mask & ~clr_vec) | set_vec;
    // same-ID set+clear leaves the bit set, so the clear never decrements
    inc = set_ok && !set_hit;
    dec = clr_ok && clr_hit && !same_id;
    count_nxt = busy_count + ID_WIDTH'(inc) - ID_WIDTH'(dec);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      decode_out <= '0;
      decode_valid <= 1'b0;
      busy_mask <= '0;
      busy_count <= '0;
      all_busy <= 1'b0;
      range_err <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      decode_out <= set_ok ? set_vec : decode_out;
      decode_valid <= set_ok;
      busy_mask <= busy_nxt;
      busy_count <= count_nxt;
      all_busy <= count_nxt == FULL;
      range_err <= range_err | (set_en && !set_ok) | (clr_en && !clr_ok);
      proto_err <= proto_err | (!same_id && ((set_ok && set_hit) || (clr_ok && !clr_hit)));
    end
  end
`ifdef WFID_TRACKER_FREE_ENCODE_EN
  logic [ID_WIDTH-1:0] free_nxt;
  logic free_any;
  // Scan downward so the lowest free index is the last one written
  always_comb begin
    free_nxt = '0;
    free_any = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!busy_nxt[i]) begin
        free_nxt = ID_WIDTH'(i);
        free_any = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      free_wfid <= '0;
      free_valid <= 1'b0;
    end else begin
      free_wfid <= free_nxt;
      free_valid <= free_any;
    end
  end
`endif
endmodule

// File: tb/tb_wfid_onehot_tracker.sv
// tb_wfid_onehot_tracker: directed scoreboard bench for wfid_onehot_tracker
module tb_wfid_onehot_tracker;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic set_en = 1'b0;
  logic [5:0] set_wfid = '0;
  logic clr_en = 1'b0;
  logic [5:0] clr_wfid = '0;
  logic [39:0] decode_out, busy_mask;
  logic decode_valid, all_busy, range_err, proto_err;
  logic [5:0] busy_count;
`ifdef WFID_TRACKER_FREE_ENCODE_EN
  logic [5:0] free_wfid;
  logic free_valid;
`endif
  typedef struct {
    logic rs;
    logic [39:0] mask;
    logic [5:0] cnt;
    logic [39:0] dec;
    logic dv, all, re, pe;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0;
  int passed = 0;
  always #5 clk = ~clk;
  wfid_onehot_tracker dut (
    .clk(clk), .rst(rst),
    .set_en(set_en), .set_wfid(set_wfid),
    .clr_en(clr_en), .clr_wfid(clr_wfid),
    .decode_out(decode_out), .decode_valid(decode_valid),
    .busy_mask(busy_mask), .busy_count(busy_count),
    .all_busy(all_busy), .range_err(range_err),
`ifdef WFID_TRACKER_FREE_ENCODE_EN
    .free_wfid(free_wfid), .free_valid(free_valid),
`endif
    .proto_err(proto_err)
  );
  function automatic logic [39:0] oh(input int i);
    logic [39:0] t;
    t = 40'd1 << i;
    return t;
  endfunction
  function automatic logic [39:0] msk(input int n);
    logic [40:0] t;
    t = (41'd1 << n) - 41'd1;
    return t[39:0];
  endfunction
  // Drive one cycle of stimulus and queue the outputs expected after the next edge
  task automatic step(input logic r, se, input logic [5:0] sid, input logic ce,
                      input logic [5:0] cid, input logic [39:0] m, input logic [5:0] c,
                      input logic [39:0] d, input logic v, a, re, pe);
    @(posedge clk);
    #2;
    rst = r;
    set_en = se;
    set_wfid = sid;
    clr_en = ce;
    clr_wfid = cid;
    q.push_back('{!r, m, c, d, v, a, re, pe});
  endtask
  // Monitor: each edge consumes the vector queued during the previous cycle
  initial forever begin
    @(posedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      #1;
      checks++;
      if (busy_mask === e.mask && busy_count === e.cnt && decode_out === e.dec &&
          decode_valid === e.dv && all_busy === e.all && range_err === e.re &&
          proto_err === e.pe)
        passed++;
      else
        $display("FAIL check%0d: got mask=%h cnt=%0d dec=%h dv=%b all=%b re=%b pe=%b, want mask=%h cnt=%0d dec=%h dv=%b all=%b re=%b pe=%b",
                 checks, busy_mask, busy_count, decode_out, decode_valid, all_busy, range_err,
                 proto_err, e.mask, e.cnt, e.dec, e.dv, e.all, e.re, e.pe);
`ifdef WFID_TRACKER_FREE_ENCODE_EN
      begin
        logic [5:0] fw;
        logic fv;
        fw = '0;
        fv = 1'b0;
        for (int i = 39; i >= 0; i--) if (!e.mask[i]) begin fw = 6'(i); fv = 1'b1; end
        if (e.rs) begin fw = '0; fv = 1'b0; end
        checks++;
        if (free_wfid === fw && free_valid === fv) passed++;
        else $display("FAIL free%0d: got free_wfid=%0d free_valid=%b, want %0d %b",
                      checks, free_wfid, free_valid, fw, fv);
      end
`endif
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", checks);
    $fatal(1);
  end
  initial begin
    step(0, 1, 5, 0, 0, '0, 0, '0, 0, 0, 0, 0);
    step(0, 1, 5, 0, 0, '0, 0, '0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, '0, 0, '0, 0, 0, 0, 0);
    step(1, 1, 39, 0, 0, oh(39), 1, oh(39), 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, oh(39), 1, oh(39), 0, 0, 0, 0);
    step(1, 0, 0, 1, 39, '0, 0, oh(39), 0, 0, 0, 0);
    for (int i = 0; i < 40; i++)
      step(1, 1, 6'(i), 0, 0, msk(i + 1), 6'(i + 1), oh(i), 1, i == 39, 0, 0);
    for (int i = 39; i >= 0; i--)
      step(1, 0, 0, 1, 6'(i), msk(i), 6'(i), oh(39), 0, 0, 0, 0);
    step(1, 1, 7, 1, 7, oh(7), 1, oh(7), 1, 0, 0, 0);
    step(1, 1, 8, 1, 7, oh(8), 1, oh(8), 1, 0, 0, 0);
    step(1, 1, 40, 0, 0, oh(8), 1, oh(8), 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, oh(8), 1, oh(8), 0, 0, 1, 0);
    step(1, 1, 3, 0, 0, oh(8) | oh(3), 2, oh(3), 1, 0, 1, 0);
    step(1, 1, 3, 0, 0, oh(8) | oh(3), 2, oh(3), 1, 0, 1, 1);
    step(1, 1, 9, 1, 50, oh(8) | oh(3) | oh(9), 3, oh(9), 1, 0, 1, 1);
    step(0, 0, 0, 0, 0, '0, 0, '0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 12, '0, 0, '0, 0, 0, 0, 1);
    step(1, 1, 4, 0, 0, oh(4), 1, oh(4), 1, 0, 0, 1);
    step(1, 1, 4, 1, 4, oh(4), 1, oh(4), 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, oh(4), 1, oh(4), 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expected vectors never checked, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
